dec_to_bin: RTL and testbench



---
 rtl/dec_to_bin_pkg.sv | 23 ++
 rtl/bcd_digit_chk.sv | 26 ++
 rtl/dec_to_bin.sv | 72 +++++++
 tb/tb_dec_to_bin.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/dec_to_bin_pkg.sv
// dec_to_bin_pkg: shared widths, limits and types for the BCD-to-binary converter.
//   DIGIT_W      - width of one BCD digit
//   BCD_MAX      - largest legal BCD code
//   ERR_CNT_W    - width of the saturating illegal-digit counter
//   bcd_digit_t  - one BCD digit / its 4-bit binary value
//   BCD_SAT_VAL  - value substituted for illegal codes in the clamping build
package dec_to_bin_pkg;

  localparam int unsigned DIGIT_W   = 4;
  localparam int unsigned ERR_CNT_W = 8;

  typedef logic [DIGIT_W-1:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX     = 4'd9;
  localparam bcd_digit_t BCD_SAT_VAL = 4'd9;

  localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = '1;

  function automatic logic bcd_is_legal(input bcd_digit_t digit);
    return digit <= BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_digit_chk.sv
// bcd_digit_chk: combinational legality check and value mapping for one BCD digit.
//   digit_i - BCD code to examine
//   legal_o - 1 when digit_i is in 0..9
//   value_o - binary value of a legal digit; the substitute value for an illegal one
// Build option: DEC_TO_BIN_SAT_EN defined -> illegal codes map to BCD_SAT_VAL (9),
//               otherwise illegal codes map to 0.
module bcd_digit_chk
  import dec_to_bin_pkg::*;
(
  input  bcd_digit_t digit_i,
  output logic       legal_o,
  output bcd_digit_t value_o
);

`ifdef DEC_TO_BIN_SAT_EN
  localparam bcd_digit_t IllegalVal = BCD_SAT_VAL;
`else
  localparam bcd_digit_t IllegalVal = '0;
`endif

  always_comb begin
    legal_o = bcd_is_legal(digit_i);
    value_o = legal_o ? digit_i : IllegalVal;
  end

endmodule

// File: rtl/dec_to_bin.sv
// dec_to_bin: registered single-digit BCD to 4-bit binary converter, 1-cycle latency.
//   clk       - rising-edge clock
//   rst_n     - asynchronous active-low reset
//   valid_in  - decimal is valid this cycle
//   decimal   - BCD digit, legal range 0..9
//   valid_out - binary/err are valid this cycle
//   binary    - unsigned binary value of the sampled digit
//   err       - sampled digit was an illegal code (>9)
//   err_cnt   - saturating count of accepted illegal digits since reset
// Build option: DEC_TO_BIN_SAT_EN clamps illegal codes to 9 instead of 0 (see bcd_digit_chk).
module dec_to_bin
  import dec_to_bin_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 valid_in,
  input  logic [DIGIT_W-1:0]   decimal,
  output logic                 valid_out,
  output logic [DIGIT_W-1:0]   binary,
  output logic                 err,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  logic       chk_legal;
  bcd_digit_t chk_value;

  logic                 valid_d, valid_q;
  bcd_digit_t           binary_d, binary_q;
  logic                 err_d, err_q;
  logic [ERR_CNT_W-1:0] err_cnt_d, err_cnt_q;

  bcd_digit_chk u_chk (
    .digit_i (decimal),
    .legal_o (chk_legal),
    .value_o (chk_value)
  );

  always_comb begin
    valid_d   = valid_in;
    binary_d  = binary_q;
    err_d     = err_q;
    err_cnt_d = err_cnt_q;
    // decimal is only looked at when valid_in is high, so X on an idle bus never propagates.
    if (valid_in) begin
      binary_d = chk_value;
      err_d    = ~chk_legal;
      if (!chk_legal && (err_cnt_q != ERR_CNT_MAX)) begin
        err_cnt_d = err_cnt_q + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      binary_q  <= '0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      valid_q   <= valid_d;
      binary_q  <= binary_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign valid_out = valid_q;
  assign binary    = binary_q;
  assign err       = err_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_dec_to_bin.sv
// tb_dec_to_bin: directed and randomized checks of dec_to_bin against a behavioural model.
module tb_dec_to_bin;

  logic       clk;
  logic       rst_n;
  logic       valid_in;
  logic [3:0] decimal;
  logic       valid_out;
  logic [3:0] binary;
  logic       err;
  logic [7:0] err_cnt;

  int errors = 0;
  int checks = 0;

  // Behavioural model state
  int m_valid;
  int m_bin;
  int m_err;
  int m_cnt;

`ifdef DEC_TO_BIN_SAT_EN
  localparam int IllegalBin = 9;
`else
  localparam int IllegalBin = 0;
`endif

  dec_to_bin dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid_in  (valid_in),
    .decimal   (decimal),
    .valid_out (valid_out),
    .binary    (binary),
    .err       (err),
    .err_cnt   (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".valid_out"}, {7'd0, valid_out}, m_valid[7:0]);
    chk({tag, ".binary"}, {4'd0, binary}, m_bin[7:0]);
    chk({tag, ".err"}, {7'd0, err}, m_err[7:0]);
    chk({tag, ".err_cnt"}, err_cnt, m_cnt[7:0]);
  endtask

  task automatic model_reset();
    m_valid = 0;
    m_bin   = 0;
    m_err   = 0;
    m_cnt   = 0;
  endtask

  task automatic model_step(input int v, input int d);
    m_valid = v;
    if (v != 0) begin
      if (d <= 9) begin
        m_bin = d;
        m_err = 0;
      end else begin
        m_bin = IllegalBin;
        m_err = 1;
        m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
      end
    end
  endtask

  // Called just after a falling edge: drive, let one rising edge sample, check at the next fall.
  task automatic step(input string tag, input logic v, input logic [3:0] d);
    valid_in = v;
    decimal  = v ? d : 4'bx;
    @(posedge clk);
    model_step(int'(v), int'(d));
    @(negedge clk);
    chk_all(tag);
  endtask

  initial begin
    model_reset();
    rst_n    = 1'b0;
    valid_in = 1'b0;
    decimal  = 4'd0;

    // Reset state before any clock edge
    #2;
    chk_all("reset_initial");
    @(negedge clk);
    rst_n = 1'b1;

    // Legal sweep
    for (int i = 0; i <= 9; i++) step("legal_sweep", 1'b1, 4'(i));
    chk("legal_sweep_cnt", err_cnt, 8'd0);

    // Illegal codes
    for (int i = 10; i <= 15; i++) step("illegal", 1'b1, 4'(i));
    chk("illegal_cnt6", err_cnt, 8'd6);

    // Hold while idle with an illegal code on the bus
    step("hold_load", 1'b1, 4'd7);
    for (int i = 0; i < 3; i++) begin
      valid_in = 1'b0;
      decimal  = 4'd12;
      @(posedge clk);
      model_step(0, 12);
      @(negedge clk);
      chk_all("hold_idle");
    end
    chk("hold_binary7", {4'd0, binary}, 8'd7);

    // Asynchronous reset mid-cycle: outputs clear without a clock edge
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk_all("reset_async");
    @(negedge clk);
    rst_n = 1'b1;

    // Reset mid-stream at digit 5
    for (int i = 0; i <= 4; i++) step("sweep_pre_rst", 1'b1, 4'(i));
    step("sweep_err_pre", 1'b1, 4'd13);
    valid_in = 1'b1;
    decimal  = 4'd5;
    #2;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    model_reset();
    chk_all("midstream_rst");
    valid_in = 1'b0;
    rst_n    = 1'b1;
    step("post_rst_idle", 1'b0, 4'd0);
    step("post_rst_first", 1'b1, 4'd6);

    // Counter saturation
    for (int i = 0; i < 300; i++) step("saturate", 1'b1, 4'(10 + ($urandom % 6)));
    chk("saturate_cnt255", err_cnt, 8'd255);
    step("sat_legal4", 1'b1, 4'd4);

    // Randomized traffic after a fresh reset
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 200; i++) begin
      step("random", 1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
